// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and write enables combinationally from the current state.
module control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_to_fsm,
    input  logic        t_branch,
    output logic        pc_write,
    output logic        pc_write_ctrl,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        addrsrc_ctrl,
    output logic        alu_in1_ctrl,
    output logic        alu_in2_ctrl,
    output logic [2:0]  imm_ctrl,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  regwrite_ctrl,
    output logic        halted
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned IMM_W = 3;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_FENCE  = 7'b0001111;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_U = 3'b011;
    localparam logic [IMM_W-1:0] IMM_J = 3'b100;

    localparam logic [ALU_W-1:0] ALU_ADD     = 4'h0;
    localparam logic [ALU_W-1:0] ALU_SUB     = 4'h1;
    localparam logic [ALU_W-1:0] ALU_SLL     = 4'h2;
    localparam logic [ALU_W-1:0] ALU_SLT     = 4'h3;
    localparam logic [ALU_W-1:0] ALU_SLTU    = 4'h4;
    localparam logic [ALU_W-1:0] ALU_XOR     = 4'h5;
    localparam logic [ALU_W-1:0] ALU_SRL     = 4'h6;
    localparam logic [ALU_W-1:0] ALU_SRA     = 4'h7;
    localparam logic [ALU_W-1:0] ALU_OR      = 4'h8;
    localparam logic [ALU_W-1:0] ALU_AND     = 4'h9;
    localparam logic [ALU_W-1:0] ALU_PASS_B  = 4'hA;
    localparam logic [ALU_W-1:0] ALU_CMP_EQ  = 4'hB;
    localparam logic [ALU_W-1:0] ALU_CMP_LT  = 4'hC;
    localparam logic [ALU_W-1:0] ALU_CMP_LTU = 4'hD;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_EXEC_JALR,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_ALU_WB,
        S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t state, next_state;

    logic [OPC_W-1:0] opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic [ALU_W-1:0] alu_func;
    logic             unused_instr_bits;

    assign opcode            = instr_to_fsm[6:0];
    assign funct3            = instr_to_fsm[14:12];
    assign funct7_5          = instr_to_fsm[30];
    assign unused_instr_bits = ^{instr_to_fsm[31], instr_to_fsm[29:15], instr_to_fsm[11:7]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Arithmetic op from funct3/funct7; SUB only exists in the register form.
    always_comb begin
        alu_func = ALU_ADD;
        case (funct3)
            3'b000:  alu_func = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_func = ALU_SLL;
            3'b010:  alu_func = ALU_SLT;
            3'b011:  alu_func = ALU_SLTU;
            3'b100:  alu_func = ALU_XOR;
            3'b101:  alu_func = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_func = ALU_OR;
            default: alu_func = ALU_AND;
        endcase
    end

    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_ctrl = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        addrsrc_ctrl  = 1'b0;
        alu_in1_ctrl  = 1'b0;
        alu_in2_ctrl  = 1'b0;
        imm_ctrl      = IMM_I;
        alu_ctrl      = ALU_ADD;
        regwrite_ctrl = 2'b00;
        halted        = 1'b0;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            // Precompute old_pc + imm as the branch/JAL target while dispatching.
            S_DECODE: begin
                alu_in1_ctrl = 1'b1;
                alu_in2_ctrl = 1'b1;
                imm_ctrl     = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_R:             next_state = S_EXEC_R;
                    OP_I:             next_state = S_EXEC_I;
                    OP_LUI, OP_AUIPC: next_state = S_EXEC_U;
                    OP_JALR:          next_state = S_EXEC_JALR;
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                    OP_BRANCH:        next_state = S_BRANCH;
                    OP_JAL:           next_state = S_JUMP;
                    OP_FENCE:         next_state = S_FETCH;
                    default:          next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                alu_ctrl   = alu_func;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_in2_ctrl = 1'b1;
                imm_ctrl     = IMM_I;
                alu_ctrl     = alu_func;
                next_state   = S_ALU_WB;
            end
            S_EXEC_U: begin
                alu_in2_ctrl = 1'b1;
                imm_ctrl     = IMM_U;
                if (opcode == OP_AUIPC) begin
                    alu_in1_ctrl = 1'b1;
                    alu_ctrl     = ALU_ADD;
                end else begin
                    alu_ctrl     = ALU_PASS_B;
                end
                next_state = S_ALU_WB;
            end
            S_EXEC_JALR: begin
                alu_in2_ctrl = 1'b1;
                imm_ctrl     = IMM_I;
                next_state   = S_JUMP;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_in2_ctrl = 1'b1;
                imm_ctrl     = (opcode == OP_LOAD) ? IMM_I : IMM_S;
                next_state   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                addrsrc_ctrl = 1'b1;
                mdr_write    = 1'b1;
                next_state   = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                regwrite_ctrl = 2'b01;
                next_state    = S_FETCH;
            end
            S_MEM_WRITE: begin
                addrsrc_ctrl = 1'b1;
                mem_write    = 1'b1;
                next_state   = S_FETCH;
            end
            // funct3[0] inverts the sense of the compare (BNE/BGE/BGEU).
            S_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_ctrl = ALU_CMP_EQ;
                    2'b10:   alu_ctrl = ALU_CMP_LT;
                    2'b11:   alu_ctrl = ALU_CMP_LTU;
                    default: alu_ctrl = ALU_ADD;
                endcase
                if (funct3[2:1] == 2'b01) begin
                    next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else begin
                    pc_write      = t_branch ^ funct3[0];
                    pc_write_ctrl = 1'b1;
                    next_state    = S_FETCH;
                end
            end
            S_JUMP: begin
                pc_write      = 1'b1;
                pc_write_ctrl = 1'b1;
                reg_write     = 1'b1;
                regwrite_ctrl = 2'b10;
                next_state    = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_FETCH;
        endcase

        // No architectural side effects while reset is held.
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mdr_write = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle output vectors plus instruction latency checks.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_to_fsm;
    logic        t_branch;
    logic        pc_write, pc_write_ctrl, ir_write, mdr_write, mem_write, reg_write;
    logic        addrsrc_ctrl, alu_in1_ctrl, alu_in2_ctrl, halted;
    logic [2:0]  imm_ctrl;
    logic [3:0]  alu_ctrl;
    logic [1:0]  regwrite_ctrl;

    control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_to_fsm(instr_to_fsm), .t_branch(t_branch),
        .pc_write(pc_write), .pc_write_ctrl(pc_write_ctrl), .ir_write(ir_write),
        .mdr_write(mdr_write), .mem_write(mem_write), .reg_write(reg_write),
        .addrsrc_ctrl(addrsrc_ctrl), .alu_in1_ctrl(alu_in1_ctrl), .alu_in2_ctrl(alu_in2_ctrl),
        .imm_ctrl(imm_ctrl), .alu_ctrl(alu_ctrl), .regwrite_ctrl(regwrite_ctrl), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, irw, mdrw, memw, rw, as, a1, a2;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] rwc;
        logic       h;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        tb;
        outs_t       exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_XOR   = 32'h0020C1B3;
    localparam logic [31:0] I_ADDI  = 32'h40000093;
    localparam logic [31:0] I_SRAI  = 32'h40005093;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h12345097;
    localparam logic [31:0] I_LW    = 32'h0080A283;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_BBAD  = 32'h0020A463;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    function automatic outs_t o(logic pcw, logic pcwc, logic irw, logic mdrw, logic memw,
                                logic rw, logic as, logic a1, logic a2, logic [2:0] imm,
                                logic [3:0] alu, logic [1:0] rwc, logic h);
        return {pcw, pcwc, irw, mdrw, memw, rw, as, a1, a2, imm, alu, rwc, h};
    endfunction

    function automatic outs_t actual();
        return {pc_write, pc_write_ctrl, ir_write, mdr_write, mem_write, reg_write,
                addrsrc_ctrl, alu_in1_ctrl, alu_in2_ctrl, imm_ctrl, alu_ctrl,
                regwrite_ctrl, halted};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(logic r, logic [31:0] ins, logic t, outs_t e);
        vec_t v;
        v.rst = r; v.instr = ins; v.tb = t; v.exp = e;
        vq.push_back(v);
    endtask

    // Cycles from a FETCH to the next FETCH for one instruction.
    task automatic latency(string name, logic [31:0] ins, logic t, int expn);
        int n;
        instr_to_fsm = ins;
        t_branch     = t;
        n = 1;
        @(posedge clk); #1;
        while (!ir_write && n < 16) begin
            n++;
            @(posedge clk); #1;
        end
        check(name, 32'(n), 32'(expn));
    endtask

    outs_t E0, EF, EDB, EDJ, EWB, EJMP, EH;

    initial begin
        E0   = o(0,0,0,0,0,0,0,0,0,3'd0,4'h0,2'd0,0);
        EF   = o(1,0,1,0,0,0,0,0,0,3'd0,4'h0,2'd0,0);
        EDB  = o(0,0,0,0,0,0,0,1,1,3'd2,4'h0,2'd0,0);
        EDJ  = o(0,0,0,0,0,0,0,1,1,3'd4,4'h0,2'd0,0);
        EWB  = o(0,0,0,0,0,1,0,0,0,3'd0,4'h0,2'd0,0);
        EJMP = o(1,1,0,0,0,1,0,0,0,3'd0,4'h0,2'd2,0);
        EH   = o(0,0,0,0,0,0,0,0,0,3'd0,4'h0,2'd0,1);

        add(1, I_ADD, 0, E0);
        add(0, I_ADD, 0, EF);  add(0, I_ADD, 0, EDB);  add(0, I_ADD, 0, E0);  add(0, I_ADD, 0, EWB);
        add(0, I_SUB, 0, EF);  add(0, I_SUB, 0, EDB);
        add(0, I_SUB, 0, o(0,0,0,0,0,0,0,0,0,3'd0,4'h1,2'd0,0));  add(0, I_SUB, 0, EWB);
        add(0, I_XOR, 0, EF);  add(0, I_XOR, 0, EDB);
        add(0, I_XOR, 0, o(0,0,0,0,0,0,0,0,0,3'd0,4'h5,2'd0,0));  add(0, I_XOR, 0, EWB);
        add(0, I_ADDI, 0, EF); add(0, I_ADDI, 0, EDB);
        add(0, I_ADDI, 0, o(0,0,0,0,0,0,0,0,1,3'd0,4'h0,2'd0,0)); add(0, I_ADDI, 0, EWB);
        add(0, I_SRAI, 0, EF); add(0, I_SRAI, 0, EDB);
        add(0, I_SRAI, 0, o(0,0,0,0,0,0,0,0,1,3'd0,4'h7,2'd0,0)); add(0, I_SRAI, 0, EWB);
        add(0, I_LUI, 0, EF);  add(0, I_LUI, 0, EDB);
        add(0, I_LUI, 0, o(0,0,0,0,0,0,0,0,1,3'd3,4'hA,2'd0,0));  add(0, I_LUI, 0, EWB);
        add(0, I_AUIPC, 0, EF); add(0, I_AUIPC, 0, EDB);
        add(0, I_AUIPC, 0, o(0,0,0,0,0,0,0,1,1,3'd3,4'h0,2'd0,0)); add(0, I_AUIPC, 0, EWB);
        add(0, I_LW, 0, EF);   add(0, I_LW, 0, EDB);
        add(0, I_LW, 0, o(0,0,0,0,0,0,0,0,1,3'd0,4'h0,2'd0,0));
        add(0, I_LW, 0, o(0,0,0,1,0,0,1,0,0,3'd0,4'h0,2'd0,0));
        add(0, I_LW, 0, o(0,0,0,0,0,1,0,0,0,3'd0,4'h0,2'd1,0));
        add(0, I_SW, 0, EF);   add(0, I_SW, 0, EDB);
        add(0, I_SW, 0, o(0,0,0,0,0,0,0,0,1,3'd1,4'h0,2'd0,0));
        add(0, I_SW, 0, o(0,0,0,0,1,0,1,0,0,3'd0,4'h0,2'd0,0));
        add(0, I_BEQ, 1, EF);  add(0, I_BEQ, 1, EDB);
        add(0, I_BEQ, 1, o(1,1,0,0,0,0,0,0,0,3'd0,4'hB,2'd0,0));
        add(0, I_BNE, 1, EF);  add(0, I_BNE, 1, EDB);
        add(0, I_BNE, 1, o(0,1,0,0,0,0,0,0,0,3'd0,4'hB,2'd0,0));
        add(0, I_BNE, 0, EF);  add(0, I_BNE, 0, EDB);
        add(0, I_BNE, 0, o(1,1,0,0,0,0,0,0,0,3'd0,4'hB,2'd0,0));
        add(0, I_BGE, 0, EF);  add(0, I_BGE, 0, EDB);
        add(0, I_BGE, 0, o(1,1,0,0,0,0,0,0,0,3'd0,4'hC,2'd0,0));
        add(0, I_BLTU, 0, EF); add(0, I_BLTU, 0, EDB);
        add(0, I_BLTU, 0, o(0,1,0,0,0,0,0,0,0,3'd0,4'hD,2'd0,0));
        add(0, I_JAL, 0, EF);  add(0, I_JAL, 0, EDJ);  add(0, I_JAL, 0, EJMP);
        add(0, I_JALR, 0, EF); add(0, I_JALR, 0, EDB);
        add(0, I_JALR, 0, o(0,0,0,0,0,0,0,0,1,3'd0,4'h0,2'd0,0)); add(0, I_JALR, 0, EJMP);
        add(0, I_FENCE, 0, EF); add(0, I_FENCE, 0, EDB);
        // Reset asserted during MEM_READ: load suppressed, restart at FETCH.
        add(0, I_LW, 0, EF);   add(0, I_LW, 0, EDB);
        add(0, I_LW, 0, o(0,0,0,0,0,0,0,0,1,3'd0,4'h0,2'd0,0));
        add(1, I_LW, 0, o(0,0,0,0,0,0,1,0,0,3'd0,4'h0,2'd0,0));
        add(0, I_FENCE, 0, EF); add(0, I_FENCE, 0, EDB);
        // Illegal opcode halts until reset, whatever instruction follows.
        add(0, 32'h0, 0, EF);  add(0, 32'h0, 0, EDB);  add(0, 32'h0, 0, EH);
        add(0, I_ADD, 1, EH);  add(1, I_ADD, 0, EH);
        add(0, I_ECALL, 0, EF); add(0, I_ECALL, 0, EDB); add(0, I_ECALL, 0, EH);
        add(1, I_FENCE, 0, EH);
        add(0, I_BBAD, 1, EF); add(0, I_BBAD, 1, EDB); add(0, I_BBAD, 1, E0);
        add(0, I_BBAD, 1, EH); add(1, I_BBAD, 1, EH);
        add(0, I_FENCE, 0, EF); add(0, I_FENCE, 0, EDB);

        rst = 1'b1; instr_to_fsm = 32'h0; t_branch = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            rst          = vq[i].rst;
            instr_to_fsm = vq[i].instr;
            t_branch     = vq[i].tb;
            #1;
            check($sformatf("vec%0d", i), 32'(actual()), 32'(vq[i].exp));
            @(posedge clk); #1;
        end

        rst = 1'b0;
        latency("lat_add",   I_ADD,   0, 4);
        latency("lat_lw",    I_LW,    0, 5);
        latency("lat_sw",    I_SW,    0, 4);
        latency("lat_beq",   I_BEQ,   1, 3);
        latency("lat_jal",   I_JAL,   0, 3);
        latency("lat_jalr",  I_JALR,  0, 4);
        latency("lat_lui",   I_LUI,   0, 4);
        latency("lat_auipc", I_AUIPC, 0, 4);
        latency("lat_fence", I_FENCE, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
